// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's operand muxes and the multiply/divide unit.
// Latency: none; this is wiring only.
// Backpressure: the core holds off new requests while busy is high.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Latency: XLEN+1 edges from acceptance to the done pulse, for every op and special case.
// Backpressure: start is ignored while busy; the result holds until the next accepted start finishes.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   a_q;        // raw operand A, returned by REM/REMU on divide-by-zero
    logic [XLEN-1:0]   bmag_q;     // multiplicand / divisor magnitude
    logic [2*XLEN-1:0] acc_q;      // {partial product | remainder, multiplier | quotient}
    logic [2:0]        op_q;
    logic              neg_q, div0_q, ovf_q;
    logic [CW-1:0]     cnt_q;

    // Operand signedness and magnitudes, evaluated on the incoming request.
    logic            a_sgn, b_sgn, a_neg, b_neg, is_rem_in, neg_d, div0_d, ovf_d;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_sgn     = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        b_sgn     = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
        a_neg     = a_sgn & bus.a[XLEN-1];
        b_neg     = b_sgn & bus.b[XLEN-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        is_rem_in = bus.op[2] & bus.op[1];
        neg_d     = is_rem_in ? a_neg : (a_neg ^ b_neg);
        div0_d    = bus.op[2] & (bus.b == '0);
        ovf_d     = (bus.op == 3'd4 || bus.op == 3'd6) &&
                    (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    end

    // One iteration step of either algorithm on the shared accumulator.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] step_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? bmag_q : {XLEN{1'b0}})};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, bmag_q};
        if (!op_q[2])
            step_d = {mul_sum, acc_q[XLEN-1:1]};
        else if (!div_diff[XLEN])
            step_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            step_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Sign fix-up and special-case selection of the finished accumulator.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot, rem, fin_res;

    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quot   = acc_q[XLEN-1:0];
        rem    = acc_q[2*XLEN-1:XLEN];
        if (!op_q[2])
            fin_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else if (div0_q)
            fin_res = op_q[1] ? a_q : '1;
        else if (ovf_q)
            fin_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (op_q[1])
            fin_res = neg_q ? -rem : rem;
        else
            fin_res = neg_q ? -quot : quot;
    end

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            bmag_q   <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
                        a_q     <= bus.a;
                        bmag_q  <= b_mag;
                        acc_q   <= {{XLEN{1'b0}}, a_mag};
                        op_q    <= bus.op;
                        neg_q   <= neg_d;
                        div0_q  <= div0_d;
                        ovf_q   <= ovf_d;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CW'(XLEN)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fin_res;
                    end else begin
                        acc_q <= step_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for the iterative multiply/divide unit.
// Latency: each op is expected to finish exactly 33 edges after acceptance.
// Backpressure: exercises start-while-busy, start-in-done-cycle and reset mid-operation.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Issues one op from a post-edge instant and waits (bounded) for done.
    // lat counts edges after acceptance; bcnt counts busy samples before done;
    // moved flags a result change before done.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt, output logic [31:0] res,
                         output bit moved);
        logic [31:0] r0;
        r0        = bus.result;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
        bus.op    = 3'd3;
        lat   = 0;
        bcnt  = 0;
        moved = 1'b0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done !== 1'b1) begin
                if (bus.busy === 1'b1) bcnt++;
                if (bus.result !== r0) moved = 1'b1;
            end
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst = 1'b0;
    endtask

    task automatic test_mul_basic();
        int lat, bcnt; logic [31:0] res; bit moved;
        do_op(3'd0, 32'd7, 32'd6, lat, bcnt, res, moved);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        n_cmp++; if (res !== 32'h0000_002A) begin n_bad++; $display("FAIL mul_result got=%h exp=0000002a", res); end
        n_cmp++; if (bcnt !== 32) begin n_bad++; $display("FAIL mul_busy_cycles got=%0d exp=32", bcnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_at_done got=%b exp=0", bus.busy); end
        n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL mul_result_stable got=%b exp=0", moved); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{3'd3, 3'd1, 3'd2};
        logic [31:0] exps[3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        int lat, bcnt; logic [31:0] res; bit moved;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, res, moved);
            n_cmp++; if (res !== exps[i]) begin n_bad++; $display("FAIL mulh_op%0d got=%h exp=%h", ops[i], res, exps[i]); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [7] = '{3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int lat, bcnt; logic [31:0] res; bit moved;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], lat, bcnt, res, moved);
            n_cmp++; if (res !== exps[i]) begin n_bad++; $display("FAIL div_vec%0d got=%h exp=%h", i, res, exps[i]); end
            n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_lat_vec%0d got=%0d exp=33", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit moved;
        bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == 9) begin
                bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_ignore_lat got=%0d exp=33", lat); end
        n_cmp++; if (bus.result !== 32'd12) begin n_bad++; $display("FAIL b2b_ignore_result got=%h exp=0000000c", bus.result); end
        // Start in the done cycle must be accepted.
        bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_drop got=%b exp=0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
        lat = 0; moved = 1'b0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done !== 1'b1 && bus.result !== 32'd12) moved = 1'b1;
        end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_lat got=%0d exp=33", lat); end
        n_cmp++; if (bus.result !== 32'd3) begin n_bad++; $display("FAIL b2b_result got=%h exp=00000003", bus.result); end
        n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got=%b exp=0", moved); end
    endtask

    task automatic test_reset_midop();
        int lat, bcnt; logic [31:0] res; bit moved; bit seen;
        bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
        do_op(3'd0, 32'd2, 32'd3, lat, bcnt, res, moved);
        n_cmp++; if (res !== 32'd6) begin n_bad++; $display("FAIL rstmid_mul got=%h exp=00000006", res); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_divide();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
